// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Streams real-valued time-domain samples into the input RAM of a
//   decimation-in-time FFT core. Samples arrive over a valid/ready handshake,
//   are arithmetically right-shifted by IN_SHIFT, paired with a zero imaginary
//   part and written at bit-reversed addresses. Once a full frame is written
//   the core is started, and the loader waits for its finish indication
//   before accepting the next frame.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   s_valid      : upstream sample valid
//   s_ready      : loader can accept a sample (high only in LOAD)
//   s_data       : signed real sample, DATA_WIDTH bits
//   mem_we       : RAM write enable, one cycle per accepted sample
//   mem_addr     : RAM write address (bit-reversed sample index)
//   mem_wdata    : {re, im}, re in the upper half, im always zero
//   fft_start    : one-cycle start pulse to the FFT core
//   fft_finish   : FFT core finished; only honoured while waiting for it
//   busy         : high whenever the loader is not accepting samples
//   frame_count  : completed frames, wraps 255 -> 0
module fft_input_loader #(
   parameter int N_SAMPLES  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int IN_SHIFT   = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_WIDTH-1:0]     s_data,
   output logic                      mem_we,
   output logic [$clog2(N_SAMPLES)-1:0] mem_addr,
   output logic [2*DATA_WIDTH-1:0]   mem_wdata,
   output logic                      fft_start,
   input  logic                      fft_finish,
   output logic                      busy,
   output logic [7:0]                frame_count
);

   localparam int LOG2N = $clog2(N_SAMPLES);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FLUSH = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [LOG2N-1:0]        cnt_q, cnt_d;
   logic                    mem_we_q, mem_we_d;
   logic [LOG2N-1:0]        mem_addr_q, mem_addr_d;
   logic [2*DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [7:0]              frame_count_q, frame_count_d;

   logic                    handshake;
   logic [LOG2N-1:0]        cnt_rev;
   logic signed [DATA_WIDTH-1:0] sample_shifted;

   // Arithmetic shift keeps the sign, so negative values round toward -inf.
   assign sample_shifted = $signed(s_data) >>> IN_SHIFT;

   always_comb begin
      cnt_rev = '0;
      for (int unsigned i = 0; i < LOG2N; i++) begin
         cnt_rev[i] = cnt_q[LOG2N-1-i];
      end
   end

   // s_ready is a pure decode of the state register, so the handshake term
   // only feeds next-state logic and never reaches an output combinationally.
   assign handshake = s_valid && (state_q == LOAD);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      frame_count_d = frame_count_q;

      case (state_q)
         LOAD: begin
            if (handshake) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_rev;
               mem_wdata_d = {sample_shifted, {DATA_WIDTH{1'b0}}};
               if (cnt_q == LOG2N'(N_SAMPLES - 1)) begin
                  cnt_d   = '0;
                  state_d = FLUSH;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         // One idle cycle lets the final write land in RAM before the core starts.
         FLUSH: state_d = START;
         START: state_d = WAIT;
         WAIT: begin
            if (fft_finish) begin
               state_d       = LOAD;
               frame_count_d = frame_count_q + 8'd1;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= LOAD;
         cnt_q         <= '0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign s_ready     = (state_q == LOAD);
   assign busy        = (state_q != LOAD);
   assign fft_start   = (state_q == START);
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Testbench for fft_input_loader: scoreboard of expected RAM writes checked by
// a negedge monitor, plus per-scenario checks of handshake, start pulse,
// finish handling, frame counting, shift scaling and reset behaviour.
module tb_fft_input_loader;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        mem_we;
   logic [2:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        fft_start;
   logic        fft_finish = 1'b0;
   logic        busy;
   logic [7:0]  frame_count;

   logic        s_valid_b = 1'b0;
   logic        s_ready_b;
   logic [15:0] s_data_b = '0;
   logic        mem_we_b;
   logic [2:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;
   logic        fft_start_b;
   logic        fft_finish_b = 1'b0;
   logic        busy_b;
   logic [7:0]  frame_count_b;

   fft_input_loader #(.N_SAMPLES(8), .DATA_WIDTH(16), .IN_SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .fft_start(fft_start), .fft_finish(fft_finish),
      .busy(busy), .frame_count(frame_count)
   );

   fft_input_loader #(.N_SAMPLES(8), .DATA_WIDTH(16), .IN_SHIFT(2)) dut_shift (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b),
      .s_data(s_data_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .fft_start(fft_start_b), .fft_finish(fft_finish_b),
      .busy(busy_b), .frame_count(frame_count_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t q[$];
   exp_t q_b[$];
   exp_t mon_e;
   exp_t mon_eb;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cnt = 0;
   int start_cyc = -1;
   int last_hs = 0;
   int mcnt = 0;
   int exp_fc = 0;
   int addr_order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor and start-pulse recorder, sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            mon_e = q.pop_front();
            if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.wdata) begin
               bad++;
               $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_addr, mem_wdata, mon_e.addr, mon_e.wdata);
            end
         end
      end
      if (mem_we_b === 1'b1) begin
         total++;
         if (q_b.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write_shift: got addr=%0d data=%h, required no write", mem_addr_b, mem_wdata_b);
         end else begin
            mon_eb = q_b.pop_front();
            if (mem_addr_b !== mon_eb.addr || mem_wdata_b !== mon_eb.wdata) begin
               bad++;
               $display("FAIL write_shift: got addr=%0d data=%h, required addr=%0d data=%h",
                        mem_addr_b, mem_wdata_b, mon_eb.addr, mon_eb.wdata);
            end
         end
      end
      if (fft_start === 1'b1) begin
         start_cnt++;
         start_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // All tasks start and end 1 time unit after a rising edge, with the DUT in LOAD
   // unless stated otherwise.
   task automatic send(input logic [15:0] d, input int gap);
      exp_t e;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = d;
      e.addr  = 3'(addr_order[mcnt]);
      e.wdata = {d, 16'h0000};
      q.push_back(e);
      mcnt = (mcnt + 1) % N;
      @(posedge clk); #1;
      last_hs = cyc;
      s_valid = 1'b0;
   endtask

   // Called right after the last handshake of a frame.
   task automatic check_frame_end(input string tag);
      int s0;
      s0 = start_cnt;
      total++;
      if (s_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_flush: got s_ready=%b busy=%b, required 0 1", tag, s_ready, busy);
      end
      repeat (4) begin @(posedge clk); #1; end
      // FLUSH occupies the cycle after the last handshake, START the one after.
      total++;
      if (start_cnt - s0 != 1 || start_cyc != last_hs + 1) begin
         bad++;
         $display("FAIL %s_start: got pulses=%0d at cyc=%0d, required 1 at cyc=%0d",
                  tag, start_cnt - s0, start_cyc, last_hs + 1);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_writes: got %0d writes missing, required 0", tag, q.size());
      end
      total++;
      if (s_ready !== 1'b0 || busy !== 1'b1 || fft_start !== 1'b0) begin
         bad++;
         $display("FAIL %s_wait: got s_ready=%b busy=%b start=%b, required 0 1 0", tag, s_ready, busy, fft_start);
      end
   endtask

   // Called in WAIT.
   task automatic finish_frame(input string tag);
      fft_finish = 1'b1;
      @(posedge clk); #1;
      fft_finish = 1'b0;
      exp_fc = (exp_fc + 1) % 256;
      total++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || frame_count !== 8'(exp_fc)) begin
         bad++;
         $display("FAIL %s_finish: got s_ready=%b busy=%b frames=%0d, required 1 0 %0d",
                  tag, s_ready, busy, frame_count, exp_fc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_valid = 1'b1;
      s_data = 16'h1234;
      fft_finish = 1'b1;
      #3;
      total++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 3'd0 ||
          mem_wdata !== 32'h0 || fft_start !== 1'b0 || frame_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_values: got rdy=%b busy=%b we=%b addr=%0d wd=%h st=%b fc=%0d, required 1 0 0 0 0 0 0",
                  s_ready, busy, mem_we, mem_addr, mem_wdata, fft_start, frame_count);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (mem_we !== 1'b0 || s_ready !== 1'b1 || frame_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_held: got we=%b rdy=%b fc=%0d, required 0 1 0", mem_we, s_ready, frame_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      s_valid = 1'b0;
      fft_finish = 1'b0;
      mcnt = 0;
      exp_fc = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 8; i++) send(16'(i), 0);
      check_frame_end("b2b");
      finish_frame("b2b");
   endtask

   task automatic test_bubbles();
      for (int i = 0; i < 8; i++) begin
         send(16'h0100 + 16'(i * 3), (i == 0) ? 2 : int'($urandom_range(0, 3)));
      end
      check_frame_end("bubbles");
      finish_frame("bubbles");
   endtask

   task automatic test_finish_ignored();
      int s0;
      fft_finish = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      fft_finish = 1'b0;
      total++;
      if (s_ready !== 1'b1 || frame_count !== 8'(exp_fc)) begin
         bad++;
         $display("FAIL finish_in_load: got rdy=%b fc=%0d, required 1 %0d", s_ready, frame_count, exp_fc);
      end
      for (int i = 0; i < 7; i++) send(16'hF000 + 16'(i), 0);
      s0 = start_cnt;
      send(16'hF007, 0);
      fft_finish = 1'b1;            // present through the FLUSH and START edges
      @(posedge clk); #1;
      total++;
      if (fft_start !== 1'b1 || frame_count !== 8'(exp_fc)) begin
         bad++;
         $display("FAIL finish_in_flush: got start=%b fc=%0d, required 1 %0d", fft_start, frame_count, exp_fc);
      end
      @(posedge clk); #1;
      fft_finish = 1'b0;
      total++;
      if (s_ready !== 1'b0 || busy !== 1'b1 || frame_count !== 8'(exp_fc)) begin
         bad++;
         $display("FAIL finish_in_start: got rdy=%b busy=%b fc=%0d, required 0 1 %0d",
                  s_ready, busy, frame_count, exp_fc);
      end
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (s_ready !== 1'b0 || start_cnt - s0 != 1 || q.size() != 0) begin
         bad++;
         $display("FAIL finish_wait_hold: got rdy=%b pulses=%0d pending=%0d, required 0 1 0",
                  s_ready, start_cnt - s0, q.size());
      end
      finish_frame("ignored");
   endtask

   task automatic test_hold_valid();
      exp_t e;
      int ready_seen;
      for (int i = 0; i < 8; i++) send(16'h0200 + 16'(i), 0);
      s_valid = 1'b1;
      s_data  = 16'h7777;
      ready_seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (s_ready !== 1'b0) ready_seen++;
      end
      total++;
      if (ready_seen != 0) begin
         bad++;
         $display("FAIL hold_ready: got %0d ready cycles, required 0", ready_seen);
      end
      fft_finish = 1'b1;
      e.addr  = 3'(addr_order[0]);
      e.wdata = {16'h7777, 16'h0000};
      q.push_back(e);
      mcnt = 1;
      @(posedge clk); #1;
      fft_finish = 1'b0;
      exp_fc = (exp_fc + 1) % 256;
      total++;
      if (s_ready !== 1'b1 || frame_count !== 8'(exp_fc) || q.size() != 1) begin
         bad++;
         $display("FAIL hold_release: got rdy=%b fc=%0d pending=%0d, required 1 %0d 1",
                  s_ready, frame_count, q.size(), exp_fc);
      end
      @(posedge clk); #1;           // held sample is taken on this edge
      s_valid = 1'b0;
      for (int i = 1; i < 8; i++) send(16'h0300 + 16'(i), 0);
      check_frame_end("hold");
      finish_frame("hold");
   endtask

   task automatic send_b(input logic [15:0] d, input logic [2:0] a, input logic [31:0] w);
      exp_t e;
      s_valid_b = 1'b1;
      s_data_b  = d;
      e.addr  = a;
      e.wdata = w;
      q_b.push_back(e);
      @(posedge clk); #1;
      s_valid_b = 1'b0;
   endtask

   task automatic test_shift();
      send_b(16'hFFF8, 3'd0, 32'hFFFE_0000);
      send_b(16'h0007, 3'd4, 32'h0001_0000);
      send_b(16'hFFFF, 3'd2, 32'hFFFF_0000);
      send_b(16'h8000, 3'd6, 32'hE000_0000);
      @(posedge clk); #1;
      total++;
      if (q_b.size() != 0 || s_ready_b !== 1'b1) begin
         bad++;
         $display("FAIL shift_drain: got pending=%0d rdy=%b, required 0 1", q_b.size(), s_ready_b);
      end
   endtask

   task automatic test_frame_wrap();
      do begin
         for (int i = 0; i < 8; i++) send(16'($urandom), 0);
         repeat (3) begin @(posedge clk); #1; end
         finish_frame("wrap");
      end while (exp_fc != 0);
      total++;
      if (frame_count !== 8'd0 || q.size() != 0) begin
         bad++;
         $display("FAIL frame_wrap: got fc=%0d pending=%0d, required 0 0", frame_count, q.size());
      end
   endtask

   task automatic test_reset_midframe();
      int s0;
      for (int i = 0; i < 5; i++) send(16'h0A00 + 16'(i), 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_we !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || mem_addr !== 3'd0 ||
          mem_wdata !== 32'h0 || frame_count !== 8'd0 || q.size() != 0) begin
         bad++;
         $display("FAIL midframe_reset: got we=%b rdy=%b busy=%b addr=%0d wd=%h fc=%0d pending=%0d, required 0 1 0 0 0 0 0",
                  mem_we, s_ready, busy, mem_addr, mem_wdata, frame_count, q.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      mcnt = 0;
      exp_fc = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send(16'h0B00 + 16'(i), 0);
      check_frame_end("midframe");
      finish_frame("midframe");

      s0 = start_cnt;
      for (int i = 0; i < 8; i++) send(16'h0C00 + 16'(i), 0);
      @(posedge clk); #1;
      total++;
      if (fft_start !== 1'b1) begin
         bad++;
         $display("FAIL start_before_reset: got start=%b, required 1", fft_start);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (fft_start !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL start_reset: got start=%b rdy=%b, required 0 1", fft_start, s_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mcnt = 0;
      exp_fc = 0;
      repeat (6) begin @(posedge clk); #1; end
      total++;
      if (start_cnt != s0 || s_ready !== 1'b1 || frame_count !== 8'd0) begin
         bad++;
         $display("FAIL start_reset_after: got pulses=%0d rdy=%b fc=%0d, required 0 1 0",
                  start_cnt - s0, s_ready, frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_finish_ignored();
      test_hold_valid();
      test_shift();
      test_frame_wrap();
      test_reset_midframe();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8: FFT frame length; power of two, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of each real and imaginary component.
REQ-003 SHALL have parameter IN_SHIFT, default 0: arithmetic right shift applied to each input sample; range 0 to DATA_WIDTH-1.
REQ-004 SHALL have local width LOG2N = $clog2(N_SAMPLES).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, as in REQ-006 and REQ-007.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port s_valid, input, 1 bit: upstream sample valid.
REQ-009 SHALL have port s_ready, output, 1 bit: loader can accept a sample.
REQ-010 SHALL have port s_data, input, DATA_WIDTH bits: signed, real-valued time-domain sample.
REQ-011 SHALL have port mem_we, output, 1 bit: write enable to the FFT input RAM port.
REQ-012 SHALL have port mem_addr, output, LOG2N bits: RAM write address.
REQ-013 SHALL have port mem_wdata, output, 2*DATA_WIDTH bits: {re, im}, with re in the upper half.
REQ-014 SHALL have port fft_start, output, 1 bit: one-cycle pulse to the FFT core's start input.
REQ-015 SHALL have port fft_finish, input, 1 bit: FFT core's finish indication.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except LOAD.
REQ-017 SHALL have port frame_count, output, 8 bits: number of completed frames; wraps from 255 to 0.

Function
REQ-018 SHALL implement the FSM states LOAD, FLUSH, START and WAIT.
REQ-019 In LOAD, SHALL drive s_ready=1; a handshake is s_valid and s_ready both high at a rising clk edge.
REQ-020 On each handshake, SHALL register on that same edge: mem_we=1, mem_addr=bitreverse(cnt), mem_wdata={s_data>>>IN_SHIFT, 0}; cnt then increments.
REQ-021 SHALL hold mem_we for exactly one cycle per handshake; mem_we=0 in cycles without a new handshake.
REQ-022 SHALL let bubbles (s_valid low) stall the loader without writes or count change; cnt holds.
REQ-023 On the handshake where cnt==N_SAMPLES-1, SHALL go LOAD->FLUSH and reset cnt to 0; s_ready drops the next cycle.
REQ-024 SHALL stay in FLUSH for one cycle (the last write is visible), then go to START.
REQ-025 In START, SHALL assert fft_start=1 for exactly one cycle, then go to WAIT.
REQ-026 SHALL drive fft_start=1 only in START, two cycles after the last handshake edge.
REQ-027 In WAIT, SHALL drive s_ready=0; when fft_finish=1 at an edge, SHALL go to LOAD and increment frame_count.
REQ-028 SHALL ignore fft_finish in LOAD, FLUSH and START (no state or count change).
REQ-029 SHALL keep s_ready=0 in FLUSH, START and WAIT; s_valid in those states SHALL be ignored, with no write.
REQ-030 SHALL compute the re component by sign-preserving arithmetic shift, truncated toward minus infinity; im is always 0.
REQ-031 SHALL write addresses for N=8 in the order 0,4,2,6,1,5,3,7 (bit-reversed input order for the DIT core).
REQ-032 SHALL drive all outputs from registers or state decode only, with no combinational path from s_valid to any output.

Reset
REQ-033 While rst_n=0, asynchronously: state=LOAD, cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, fft_start=0, frame_count=0.
REQ-034 During reset, outputs SHALL be s_ready=1 and busy=0, by decode of LOAD.
REQ-035 Reset mid-frame SHALL discard the partial frame; the next handshake after release SHALL write mem_addr=0.
REQ-036 Reset in START or WAIT SHALL drop fft_start immediately, with no further pulse for that frame.

Verification
REQ-037 s_data=1..8 streamed back-to-back, N=8 -> writes (addr,re,im): (0,1,0),(4,2,0),(2,3,0),(6,4,0),(1,5,0),(5,6,0),(3,7,0),(7,8,0); fft_start single pulse 2 cycles after the 8th handshake.
REQ-038 s_valid toggled 1,0,0,1,... with random gaps -> write count exactly 8, order per REQ-031, no write in a gap cycle.
REQ-039 fft_finish pulsed during LOAD and FLUSH -> ignored; in WAIT -> s_ready=1 the next cycle, frame_count 0->1; 256 frames -> frame_count back to 0.
REQ-040 IN_SHIFT=2, s_data=-8 (0xFFF8) -> mem_wdata=0xFFFE_0000; s_data=7 -> 0x0001_0000; s_data=-1 -> 0xFFFF_0000.
REQ-041 rst_n asserted after the 5th handshake, released, then 8 samples -> first write addr 0, full frame, and one fft_start only.
REQ-042 s_valid held high through WAIT -> s_ready=0, no mem_we, and no sample lost, because upstream holds its data until the handshake.
